// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive control block.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        BITS     = 3'd2,
        STOP_CHK = 3'd3
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT  = 10;
    localparam int DEF_NUM_DATA_BITS = 8;
    localparam int FRAME_BITS        = DEF_NUM_DATA_BITS + 1;

    // Bit-period timer must be able to hold the full CLKS_PER_BIT value.
    function automatic int timer_width(input int clks_per_bit);
        return $clog2(clks_per_bit + 1);
    endfunction

    // Data bits plus the trailing stop bit.
    function automatic int frame_bits(input int num_data_bits);
        return num_data_bits + 1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line and shift-register handshake between the RX controller and its datapath.
interface uart_rx_ctrl_if;
    logic serial_in;
    logic stop_bit;
    logic serial_sync;
    logic shift_strobe;
    logic load_buffer;
    logic framing_error;
    logic rx_busy;

    // Datapath / line side: drives the raw line and the shift-register MSB.
    modport master (
        output serial_in,
        output stop_bit,
        input  serial_sync,
        input  shift_strobe,
        input  load_buffer,
        input  framing_error,
        input  rx_busy
    );

    // Controller side.
    modport slave (
        input  serial_in,
        input  stop_bit,
        output serial_sync,
        output shift_strobe,
        output load_buffer,
        output framing_error,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_ctrl_bit_timer.sv
// Clear/enable up-counter that pulses rollover on the cycle its count would reach
// the programmable terminal value, then wraps to 0. Period is exactly 'term' cycles.
module rx_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic             rollover
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count + WIDTH'(1);
    assign rollover  = enable && !clear && (count_inc == term);

    // Count while enabled; clear has priority, rollover wraps to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= rollover ? '0 : count_inc;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX control: line synchroniser, start detect, bit timing, stop-bit check.
// CLKS_PER_BIT must be even and >= 4.
// Optional build macro UART_RX_START_VALIDATE_EN: re-check the line at mid start bit
// and drop back to IDLE if it has returned high (glitch rejection).
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  rx_if
);

    localparam int TW     = timer_width(CLKS_PER_BIT);
    localparam int NFRAME = frame_bits(NUM_DATA_BITS);
    localparam int CW     = $clog2(NFRAME + 1);

    localparam logic [TW-1:0] HALF_TERM = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_TERM = TW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_BIT  = CW'(NFRAME - 1);

    rx_state_t     state;
    logic [CW-1:0] bit_cnt;
    logic          framing_error_q;
    logic          sync_1;
    logic          sync_2;
    logic          sync_prev;
    logic          start_det;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_roll;
    logic [TW-1:0] timer_term;

    // Two-flop synchroniser plus edge history; idle-high line so all reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= rx_if.serial_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign start_det   = (state == IDLE) && !sync_2 && sync_prev;
    assign timer_clear = start_det;
    assign timer_en    = (state == START) || (state == BITS);
    assign timer_term  = (state == START) ? HALF_TERM : FULL_TERM;

    rx_bit_timer #(
        .WIDTH (TW)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (timer_en),
        .term     (timer_term),
        .rollover (timer_roll)
    );

    // Frame sequencing: half-bit to mid start, then one strobe per full bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            framing_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state           <= START;
                        bit_cnt         <= '0;
                        framing_error_q <= 1'b0;
                    end
                end
                START: begin
                    if (timer_roll) begin
`ifdef UART_RX_START_VALIDATE_EN
                        state <= sync_2 ? IDLE : BITS;
`else
                        state <= BITS;
`endif
                    end
                end
                BITS: begin
                    if (timer_roll) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP_CHK;
                        end
                    end
                end
                STOP_CHK: begin
                    if (!rx_if.stop_bit) begin
                        framing_error_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pulses are decoded from registered state/timer so they land on the exact
    // bit-centre cycle; stop_bit is only valid once the final shift has happened,
    // i.e. during STOP_CHK itself. Busy covers the detection cycle as well.
    assign rx_if.serial_sync   = sync_2;
    assign rx_if.shift_strobe  = (state == BITS) && timer_roll;
    assign rx_if.load_buffer   = (state == STOP_CHK) && rx_if.stop_bit;
    assign rx_if.framing_error = framing_error_q;
    assign rx_if.rx_busy       = (state != IDLE) || start_det;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame table, corner sequences, random frames.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int C        = 10;
    localparam int HALF     = C / 2;
    localparam int NDATA    = 8;
    localparam int FRAME    = NDATA + 1;
    localparam int STOP_REL = HALF + FRAME * C + 1;
`ifdef UART_RX_START_VALIDATE_EN
    localparam bit VALIDATE = 1'b1;
`else
    localparam bit VALIDATE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [8:0] env_sr = '1;

    uart_rx_ctrl_if u_if();

    uart_rx_ctrl #(
        .CLKS_PER_BIT  (C),
        .NUM_DATA_BITS (NDATA)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;

    // Receive shift register of the datapath: LSB-first, new bit enters at MSB.
    assign u_if.stop_bit = env_sr[8];
    always @(posedge clk) if (u_if.shift_strobe) env_sr <= {u_if.serial_sync, env_sr[8:1]};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit line_q[$];
    int strobe_q[$];
    int load_q[$];
    logic [7:0] last_byte;

    // Reference model state
    bit m_s1 = 1, m_s2 = 1, m_prev = 1;
    bit in_frame = 0;
    int t0 = 0, end_rel = 0;
    bit [8:0] m_sr = '1;
    bit m_fe = 0, pend_set = 0, pend_clr = 0;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         exp_load;
        bit         exp_fe;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level reference: start = falling synchronised edge while idle; strobe k at
    // T0+HALF+k*C; stop check one cycle after the last strobe; glitch abort at T0+HALF.
    task automatic model_step(output bit e_sync, output bit e_strobe, output bit e_load,
                              output bit e_fe, output bit e_busy);
        int rel;
        e_strobe = 0;
        e_load   = 0;
        if (rst) begin
            m_s1 = 1; m_s2 = 1; m_prev = 1;
            in_frame = 0; m_fe = 0; pend_set = 0; pend_clr = 0;
        end else begin
            if (pend_set) m_fe = 1;
            if (pend_clr) m_fe = 0;
            pend_set = 0;
            pend_clr = 0;
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = u_if.serial_in;
            if (in_frame && (cyc - t0 > end_rel)) in_frame = 0;
            if (!in_frame && !m_s2 && m_prev) begin
                in_frame = 1;
                t0       = cyc;
                end_rel  = STOP_REL;
                pend_clr = 1;
            end
            if (in_frame) begin
                rel = cyc - t0;
                if (VALIDATE && rel == HALF && m_s2) end_rel = HALF;
                if (end_rel == STOP_REL && rel > HALF && rel < STOP_REL && ((rel - HALF) % C) == 0) begin
                    e_strobe = 1;
                    m_sr = {m_s2, m_sr[8:1]};
                end
                if (rel == STOP_REL) begin
                    e_load = m_sr[8];
                    if (!m_sr[8]) pend_set = 1;
                end
            end
        end
        e_sync = m_s2;
        e_fe   = m_fe;
        e_busy = in_frame;
    endtask

    task automatic cycle();
        bit e_sync, e_strobe, e_load, e_fe, e_busy;
        @(negedge clk);
        cyc++;
        model_step(e_sync, e_strobe, e_load, e_fe, e_busy);
        check("serial_sync", u_if.serial_sync, e_sync);
        check("shift_strobe", u_if.shift_strobe, e_strobe);
        check("load_buffer", u_if.load_buffer, e_load);
        check("framing_error", u_if.framing_error, e_fe);
        check("rx_busy", u_if.rx_busy, e_busy);
        if (e_load) check("load_data", env_sr[7:0], m_sr[7:0]);
        if (u_if.shift_strobe) strobe_q.push_back(cyc);
        if (u_if.load_buffer) begin
            load_q.push_back(cyc);
            last_byte = env_sr[7:0];
        end
        if (line_q.size() > 0) u_if.serial_in = line_q.pop_front();
        else u_if.serial_in = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_frame(input logic [7:0] data, input bit stop);
        repeat (C) line_q.push_back(1'b0);
        for (int b = 0; b < NDATA; b++) repeat (C) line_q.push_back(data[b]);
        repeat (C) line_q.push_back(stop);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sync"}, u_if.serial_sync, 1'b1);
        check({tag, "_strobe"}, u_if.shift_strobe, 1'b0);
        check({tag, "_load"}, u_if.load_buffer, 1'b0);
        check({tag, "_fe"}, u_if.framing_error, 1'b0);
        check({tag, "_busy"}, u_if.rx_busy, 1'b0);
    endtask

    initial begin
        int p;
        int n_str0, n_ld0;
        u_if.serial_in = 1'b1;
        last_byte = '0;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b0};

        #12;
        check_reset_outputs("reset");
        run(3);
        rst = 1'b0;
        run(10);

        // Frame 0xA5 with exact strobe/load timing
        strobe_q.delete(); load_q.delete();
        p = cyc;
        push_frame(8'hA5, 1'b1);
        run(110);
        check("t1_nstrobe", strobe_q.size(), FRAME);
        if (strobe_q.size() == FRAME) begin
            check("t1_first_strobe", strobe_q[0], p + 3 + 15);
            check("t1_last_strobe", strobe_q[FRAME-1], p + 3 + 95);
        end
        check("t1_nload", load_q.size(), 1);
        if (load_q.size() == 1) check("t1_load_cyc", load_q[0], p + 3 + 96);
        check("t1_data", last_byte, 8'hA5);

        // Table of single frames
        foreach (vecs[i]) begin
            n_str0 = strobe_q.size();
            n_ld0  = load_q.size();
            push_frame(vecs[i].data, vecs[i].stop);
            run(110);
            check("vec_strobes", strobe_q.size() - n_str0, FRAME);
            check("vec_loads", load_q.size() - n_ld0, vecs[i].exp_load);
            check("vec_fe", u_if.framing_error, vecs[i].exp_fe);
            if (vecs[i].exp_load) check("vec_data", last_byte, vecs[i].data);
        end

        // Back-to-back frames
        load_q.delete();
        push_frame(8'h11, 1'b1);
        push_frame(8'h96, 1'b1);
        run(215);
        check("b2b_nload", load_q.size(), 2);
        if (load_q.size() == 2) check("b2b_spacing", load_q[1] - load_q[0], 100);
        check("b2b_data", last_byte, 8'h96);

        // Start glitch, 3 cycles low
        run(10);
        strobe_q.delete();
        repeat (3) line_q.push_back(1'b0);
        run(130);
        check("glitch_strobes", strobe_q.size(), VALIDATE ? 0 : FRAME);
        check("glitch_busy", u_if.rx_busy, 1'b0);

        // Reset mid-frame
        load_q.delete();
        p = cyc;
        push_frame(8'hC3, 1'b1);
        run(43);
        rst = 1'b1;
        line_q.delete();
        u_if.serial_in = 1'b1;
        #1;
        check_reset_outputs("midrst");
        run(2);
        rst = 1'b0;
        run(100);
        check("midrst_noload", load_q.size(), 0);
        push_frame(8'h5A, 1'b1);
        run(110);
        check("postrst_nload", load_q.size(), 1);
        check("postrst_data", last_byte, 8'h5A);

        // Break: bad stop then line held low
        strobe_q.delete(); load_q.delete();
        push_frame(8'h0F, 1'b0);
        repeat (300) line_q.push_back(1'b0);
        run(400);
        check("break_strobes", strobe_q.size(), FRAME);
        check("break_fe", u_if.framing_error, 1'b1);
        check("break_busy", u_if.rx_busy, 1'b0);
        run(20);
        check("break_rise_nostart", strobe_q.size(), FRAME);
        push_frame(8'h3E, 1'b1);
        run(110);
        check("break_recover_load", load_q.size(), 1);
        check("break_recover_fe", u_if.framing_error, 1'b0);

        // Random frames with random gaps (gap 0 exercises back-to-back)
        for (int i = 0; i < 25; i++) begin
            run($urandom_range(0, 12));
            push_frame(8'($urandom), ($urandom_range(0, 3) != 0));
            run(100);
        end
        run(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
